instr_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC and fetches 32-bit words from instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/fetch_next_pc.sv | 31 +++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: PCSrc encodings (common with the control unit),
// FSM state type and instruction field positions.
package instr_fetch_unit_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int COND_MSB = 26;
    localparam int COND_LSB = 25;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: imem request/ack port, decode valid/ready port
// and the redirect port driven back by the control unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    // imem: imem_req is held with a stable imem_addr until the single-cycle imem_ack;
    // decode: a word transfers on a cycle where instr_valid & instr_ready are both high.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [4:0]        opcode;
    logic [1:0]        cond;
    logic              redirect_valid;
    logic [1:0]        pc_src;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jr_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus1, opcode, cond,
        input  imem_ack, imem_rdata, instr_ready,
        input  redirect_valid, pc_src, jump_target, branch_target, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus1, opcode, cond,
        output imem_ack, imem_rdata, instr_ready,
        output redirect_valid, pc_src, jump_target, branch_target, jr_target
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: a redirect with a non-sequential pc_src picks its target,
// otherwise the sequential pc+1 (modulo 2^ADDR_W).
module fetch_next_pc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              redirect_valid,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        redirect = redirect_valid && (pc_src != PCSRC_SEQ);
        next_pc  = pc + ADDR_W'(1);
        if (redirect_valid) begin
            case (pc_src)
                PCSRC_JUMP:   next_pc = jump_target;
                PCSRC_BRANCH: next_pc = branch_target;
                PCSRC_JR:     next_pc = jr_target;
                default:      next_pc = pc + ADDR_W'(1);
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem fetch in flight and hands words to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_discarded counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus,
    output fetch_state_e       dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_discarded
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              discard_q, discard_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              redirect;
    logic [ADDR_W-1:0] next_pc;

    fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .redirect_valid (bus.redirect_valid),
        .pc_src         (bus.pc_src),
        .jump_target    (bus.jump_target),
        .branch_target  (bus.branch_target),
        .jr_target      (bus.jr_target),
        .pc             (pc_q),
        .redirect       (redirect),
        .next_pc        (next_pc)
    );

    // In S_HOLD pc_q still equals instr_pc_q, so next_pc doubles as the sequential successor.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                discard_d  = 1'b0;
                pc_d       = redirect ? next_pc : pc_q;
                req_addr_d = redirect ? next_pc : pc_q;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    if (discard_q || redirect) begin
                        discard_d  = 1'b0;
                        pc_d       = redirect ? next_pc : pc_q;
                        req_addr_d = redirect ? next_pc : pc_q;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = req_addr_q;
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding request must still complete; its data is dropped later.
                    pc_d      = next_pc;
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || bus.instr_ready) begin
                    pc_d       = next_pc;
                    req_addr_d = next_pc;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = req_addr_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc_plus1    = instr_pc_q + ADDR_W'(1);
    assign bus.opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign bus.cond        = instr_q[COND_MSB:COND_LSB];
    assign dbg_state       = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_discarded_q, perf_discarded_d;
    logic        accept, drop_ack, kill_held;

    // A held word accepted in the same cycle as a redirect counts as delivered, not killed.
    always_comb begin
        accept           = (state_q == S_HOLD) && bus.instr_ready;
        drop_ack         = (state_q == S_FETCH) && bus.imem_ack && (discard_q || redirect);
        kill_held        = (state_q == S_HOLD) && redirect && !bus.instr_ready;
        perf_fetched_d   = perf_fetched_q + 32'(accept);
        perf_discarded_d = perf_discarded_q + 32'(drop_ack || kill_held);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_discarded_q <= perf_discarded_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit with a transaction-level PC model
// and an imem whose contents are a fixed function of the address.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  perf_fetched;
    logic [31:0]  perf_discarded;
`endif

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned  n_assert = 0;
    int unsigned  n_fail   = 0;
    logic [15:0]  model_pc;
    logic [15:0]  held_pc;
    logic [31:0]  held_word;
    logic [31:0]  exp_fetched;
    logic [31:0]  exp_disc;
    logic [47:0]  exp_q[$];

    int           r_delay;
    int           r_redir_at;
    logic [1:0]   r_src;
    logic [15:0]  r_tgt;
    bit           r_cap;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return ({a, ~a} * 32'd2654435761) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_perf_fetched"}, 64'(perf_fetched), 64'(exp_fetched));
        check({tag, "_perf_discarded"}, 64'(perf_discarded), 64'(exp_disc));
`endif
    endtask

    task automatic drive_targets(input logic [1:0] src, input logic [15:0] tgt);
        bus.pc_src        = src;
        bus.jump_target   = (src == 2'b01) ? tgt : 16'($urandom);
        bus.branch_target = (src == 2'b10) ? tgt : 16'($urandom);
        bus.jr_target     = (src == 2'b11) ? tgt : 16'($urandom);
    endtask

    // Entered at a negedge; ends at the negedge after the ack.
    task automatic t_fetch(input int delay, input int redir_at, input logic [1:0] src,
                           input logic [15:0] tgt, output bit captured);
        int          waited;
        logic [15:0] addr;
        bit          dropped;
        logic [47:0] e;
        waited  = 0;
        dropped = 1'b0;
        while (!bus.imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", 64'(bus.imem_req), 64'(1));
        check("fetch_addr", 64'(bus.imem_addr), 64'(model_pc));
        addr = model_pc;
        for (int c = 0; c <= delay; c++) begin
            if (c > 0) begin
                check("req_hold", 64'(bus.imem_req), 64'(1));
                check("addr_hold", 64'(bus.imem_addr), 64'(addr));
                check("no_valid_in_fetch", 64'(bus.instr_valid), 64'(0));
            end
            bus.redirect_valid = (c == redir_at);
            drive_targets(src, tgt);
            if (c == redir_at && src != 2'b00) begin
                dropped  = 1'b1;
                model_pc = tgt;
            end
            bus.imem_ack   = (c == delay);
            bus.imem_rdata = (c == delay) ? mem_word(addr) : $urandom;
            @(negedge clk);
        end
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        if (dropped) begin
            exp_disc++;
            captured = 1'b0;
            check("drop_no_valid", 64'(bus.instr_valid), 64'(0));
            check("refetch_req", 64'(bus.imem_req), 64'(1));
            check("refetch_addr", 64'(bus.imem_addr), 64'(model_pc));
        end else begin
            exp_q.push_back({addr, mem_word(addr)});
            e         = exp_q.pop_front();
            held_pc   = e[47:32];
            held_word = e[31:0];
            captured  = 1'b1;
            check("valid_after_ack", 64'(bus.instr_valid), 64'(1));
            check("instr", 64'(bus.instr), 64'(held_word));
            check("instr_pc", 64'(bus.instr_pc), 64'(held_pc));
            check("opcode", 64'(bus.opcode), 64'(held_word[31:27]));
            check("cond", 64'(bus.cond), 64'(held_word[26:25]));
            check("pc_plus1", 64'(bus.pc_plus1), 64'(16'(held_pc + 16'd1)));
        end
    endtask

    task automatic t_accept(input int ready_delay, input bit redir, input logic [1:0] src,
                            input logic [15:0] tgt);
        for (int c = 0; c < ready_delay; c++) begin
            bus.instr_ready = 1'b0;
            check("hold_valid", 64'(bus.instr_valid), 64'(1));
            check("hold_instr", 64'(bus.instr), 64'(held_word));
            check("hold_pc", 64'(bus.instr_pc), 64'(held_pc));
            check("hold_no_req", 64'(bus.imem_req), 64'(0));
            @(negedge clk);
        end
        check("accept_valid", 64'(bus.instr_valid), 64'(1));
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = redir;
        drive_targets(src, tgt);
        exp_fetched++;
        if (redir && src != 2'b00) model_pc = tgt;
        else                       model_pc = held_pc + 16'd1;
        @(negedge clk);
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        check("post_accept_valid", 64'(bus.instr_valid), 64'(0));
        check("post_accept_req", 64'(bus.imem_req), 64'(1));
        check("post_accept_addr", 64'(bus.imem_addr), 64'(model_pc));
    endtask

    task automatic t_kill(input logic [1:0] src, input logic [15:0] tgt);
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b1;
        drive_targets(src, tgt);
        exp_disc++;
        model_pc = tgt;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("kill_valid", 64'(bus.instr_valid), 64'(0));
        check("kill_req", 64'(bus.imem_req), 64'(1));
        check("kill_addr", 64'(bus.imem_addr), 64'(model_pc));
    endtask

    task automatic t_reset(input int cycles);
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        drive_targets(2'b00, 16'h0);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        exp_q.delete();
        model_pc    = 16'h0000;
        exp_fetched = '0;
        exp_disc    = '0;
        check("rst_req", 64'(bus.imem_req), 64'(0));
        check("rst_addr", 64'(bus.imem_addr), 64'(16'h0000));
        check("rst_valid", 64'(bus.instr_valid), 64'(0));
        check("rst_instr", 64'(bus.instr), 64'(0));
        check("rst_instr_pc", 64'(bus.instr_pc), 64'(16'h0000));
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check_perf("rst");
        reset = 1'b0;
        @(negedge clk);
        check("first_req", 64'(bus.imem_req), 64'(1));
        check("first_addr", 64'(bus.imem_addr), 64'(16'h0000));
    endtask

    initial begin
        reset = 1'b1;
        t_reset(3);

        // Zero-wait imem, sequential addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            t_fetch(0, -1, 2'b00, 16'h0, r_cap);
            t_accept(0, 1'b0, 2'b00, 16'h0);
        end

        // Ack delayed 3 cycles, then decode stalls 4 cycles.
        t_fetch(3, -1, 2'b00, 16'h0, r_cap);
        t_accept(4, 1'b0, 2'b00, 16'h0);

        // JR redirect while 0x05 is outstanding: word dropped, refetch at 0x40.
        check("pc_before_jr", 64'(bus.imem_addr), 64'(16'h0005));
        t_fetch(2, 1, 2'b11, 16'h0040, r_cap);
        check("jr_dropped", 64'(r_cap), 64'(0));
        check("jr_target_addr", 64'(bus.imem_addr), 64'(16'h0040));

        // Branch taken in the same cycle as accept.
        t_fetch(0, -1, 2'b00, 16'h0, r_cap);
        t_accept(0, 1'b1, 2'b10, 16'h0010);
        check("branch_addr", 64'(bus.imem_addr), 64'(16'h0010));

        // Kill held word with a jump to the top of the address space, then wrap.
        t_fetch(1, -1, 2'b00, 16'h0, r_cap);
        t_kill(2'b01, 16'hFFFF);
        t_fetch(0, -1, 2'b00, 16'h0, r_cap);
        t_accept(1, 1'b0, 2'b00, 16'h0);
        check("wrap_addr", 64'(bus.imem_addr), 64'(16'h0000));

        // pc_src=00 with redirect_valid is a no-op, in fetch and in hold.
        t_fetch(1, 1, 2'b00, 16'h1234, r_cap);
        t_accept(0, 1'b1, 2'b00, 16'h5678);
        check_perf("directed");

        // Reset while a fetch is outstanding; an ack arriving in S_IDLE is ignored.
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req_drop", 64'(bus.imem_req), 64'(0));
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        model_pc     = 16'h0000;
        exp_fetched  = '0;
        exp_disc     = '0;
        check("midrst_no_valid", 64'(bus.instr_valid), 64'(0));
        check("midrst_req", 64'(bus.imem_req), 64'(1));
        check("midrst_addr", 64'(bus.imem_addr), 64'(16'h0000));

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            r_delay    = int'($urandom_range(0, 3));
            r_redir_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_delay)) : -1;
            r_src      = 2'($urandom_range(0, 3));
            r_tgt      = 16'($urandom);
            t_fetch(r_delay, r_redir_at, r_src, r_tgt, r_cap);
            if (r_cap) begin
                if ($urandom_range(0, 4) == 0)
                    t_kill(2'($urandom_range(1, 3)), 16'($urandom));
                else
                    t_accept(int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
                             2'($urandom_range(0, 3)), 16'($urandom));
            end
        end
        check_perf("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
